mode_sequencer: RTL and testbench

Host-side command sequencer driving the mode/start/data inputs of the control unit (`on`, `start`, `x`) and observing its status outputs (`regime`, `active`, `y`, `s`, `b`). It accepts one command at a time over a valid/ready handshake, arms the requested mode, holds `start` for a programmed number of cycles, then waits for the unit to return to idle. On completion it reports the unit's results, or an error on timeout.

---
 rtl/mode_seq_pkg.sv | 46 ++++
 rtl/mode_sequencer_if.sv | 25 ++
 rtl/wait_timer.sv | 34 +++
 rtl/mode_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_mode_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mode_seq_pkg.sv
// Shared definitions for the mode sequencer: state encoding, unit mode
// codes, default wait limit, the latched command record and small helpers.
package mode_seq_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ARM   = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_ERROR = 3'd5;

   localparam logic [1:0] MODE_NONE  = 2'd0;
   localparam logic [1:0] MODE_ENUM  = 2'd1;
   localparam logic [1:0] MODE_COUNT = 2'd2;
   localparam logic [1:0] MODE_UPD   = 2'd3;

   localparam int TIMEOUT_DEF = 15;

   typedef struct packed {
      logic [1:0] mode;
      logic [7:0] x;
      logic [3:0] len;
   } cmd_t;

   // Saturating 4-bit increment used by the active-cycle counter.
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      logic [3:0] r;
      if (v == 4'hF) begin
         r = v;
      end else begin
         r = v + 4'd1;
      end
      return r;
   endfunction

   // True while a command is being worked on (the unit is being driven or drained).
   function automatic logic in_cmd_phase(input logic [2:0] st);
      logic r;
      case (st)
         ST_ARM, ST_RUN, ST_DRAIN: r = 1'b1;
         default:                  r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Host-side command/result bus of the mode sequencer.
interface mode_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_mode;
   logic [7:0] cmd_x;
   logic [3:0] cmd_len;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] res_y;
   logic [2:0] res_s;
   logic       res_b;
   logic [3:0] active_cycles;

   modport master (
      output cmd_valid, cmd_mode, cmd_x, cmd_len,
      input  cmd_ready, busy, done, err, res_y, res_s, res_b, active_cycles
   );

   modport slave (
      input  cmd_valid, cmd_mode, cmd_x, cmd_len,
      output cmd_ready, busy, done, err, res_y, res_s, res_b, active_cycles
   );
endinterface

// File: rtl/wait_timer.sv
// Shared wait counter for the ARM and DRAIN phases; flags the last
// permitted wait cycle so the FSM can give up on the unit.
module wait_timer
   import mode_seq_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [3:0] LIMIT_C = 4'(TIMEOUT - 1);

   logic [3:0] count_r;

   // Clear wins over count; otherwise advance while enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= 4'd0;
      end else if (clr) begin
         count_r <= 4'd0;
      end else if (en) begin
         count_r <= count_r + 4'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == LIMIT_C);

endmodule

// File: rtl/mode_sequencer.sv
// Host-side command sequencer: accepts one command, arms the unit's mode,
// holds start for the programmed run length, waits for the unit to go idle
// and reports captured results (or a timeout error).
module mode_sequencer
   import mode_seq_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   mode_sequencer_if.slave host,
   output logic [1:0]      on,
   output logic            start,
   output logic [7:0]      x,
   input  logic [1:0]      regime,
   input  logic            active,
   input  logic [7:0]      y_in,
   input  logic [2:0]      s_in,
   input  logic            b_in
);

   logic [2:0] state_r;
   logic [2:0] state_nxt_s;
   cmd_t       cmd_r;
   cmd_t       cmd_nxt_s;
   logic [3:0] run_cnt_r;
   logic [3:0] act_cnt_r;
   logic [7:0] res_y_r;
   logic [2:0] res_s_r;
   logic       res_b_r;

   logic accept_s;
   logic tmr_clr_s;
   logic tmr_en_s;
   logic tmr_expired_s;
   logic run_load_s;
   logic capture_s;

   logic [1:0] on_nxt_s;
   logic       start_nxt_s;
   logic       done_nxt_s;
   logic       err_nxt_s;
   logic       busy_nxt_s;
   logic       ready_nxt_s;
   logic [1:0] on_r;
   logic       start_r;
   logic       done_r;
   logic       err_r;
   logic       busy_r;
   logic       ready_r;

   wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr_s),
      .en      (tmr_en_s),
      .expired (tmr_expired_s)
   );

   // Next-state and control strobes; a regime match always beats expiry.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      tmr_clr_s   = 1'b0;
      tmr_en_s    = 1'b0;
      run_load_s  = 1'b0;
      capture_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (host.cmd_valid) begin
               accept_s  = 1'b1;
               tmr_clr_s = 1'b1;
               if (host.cmd_mode == MODE_NONE) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_ARM;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (regime == cmd_r.mode) begin
               tmr_clr_s = 1'b1;
               if (cmd_r.len != 4'd0) begin
                  run_load_s  = 1'b1;
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_DRAIN;
               end
            end else if (tmr_expired_s) begin
               state_nxt_s = ST_ERROR;
            end else begin
               tmr_en_s    = 1'b1;
               state_nxt_s = ST_ARM;
            end
         end
         ST_RUN: begin
            if (run_cnt_r == 4'd1) begin
               tmr_clr_s   = 1'b1;
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (regime == MODE_NONE) begin
               capture_s   = 1'b1;
               state_nxt_s = ST_DONE;
            end else if (tmr_expired_s) begin
               state_nxt_s = ST_ERROR;
            end else begin
               tmr_en_s    = 1'b1;
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_DONE:  state_nxt_s = ST_IDLE;
         ST_ERROR: state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // Command record as it will stand after this edge.
   always_comb begin
      cmd_nxt_s = cmd_r;
      if (accept_s) begin
         cmd_nxt_s.mode = host.cmd_mode;
         cmd_nxt_s.x    = host.cmd_x;
         cmd_nxt_s.len  = host.cmd_len;
      end else begin
         cmd_nxt_s = cmd_r;
      end
   end

   // Output values for the upcoming state, so every output leaves a flop.
   always_comb begin
      on_nxt_s    = MODE_NONE;
      start_nxt_s = 1'b0;
      done_nxt_s  = 1'b0;
      err_nxt_s   = 1'b0;
      busy_nxt_s  = 1'b1;
      ready_nxt_s = 1'b0;
      case (state_nxt_s)
         ST_IDLE: begin
            busy_nxt_s  = 1'b0;
            ready_nxt_s = 1'b1;
         end
         ST_ARM: begin
            on_nxt_s    = cmd_nxt_s.mode;
            start_nxt_s = (cmd_nxt_s.len != 4'd0);
         end
         ST_RUN: begin
            on_nxt_s    = cmd_nxt_s.mode;
            start_nxt_s = 1'b1;
         end
         ST_DRAIN: begin
            busy_nxt_s = 1'b1;
         end
         ST_DONE: begin
            done_nxt_s = 1'b1;
         end
         ST_ERROR: begin
            done_nxt_s = 1'b1;
            err_nxt_s  = 1'b1;
         end
         default: begin
            busy_nxt_s  = 1'b0;
            ready_nxt_s = 1'b1;
         end
      endcase
   end

   // State, latched command and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cmd_r   <= '0;
         on_r    <= MODE_NONE;
         start_r <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         busy_r  <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         cmd_r   <= cmd_nxt_s;
         on_r    <= on_nxt_s;
         start_r <= start_nxt_s;
         done_r  <= done_nxt_s;
         err_r   <= err_nxt_s;
         busy_r  <= busy_nxt_s;
         ready_r <= ready_nxt_s;
      end
   end

   // Run-length counter: loaded when RUN is entered, counts down inside RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt_r <= 4'd0;
      end else if (run_load_s) begin
         run_cnt_r <= cmd_r.len;
      end else if (state_r == ST_RUN) begin
         run_cnt_r <= run_cnt_r - 4'd1;
      end else begin
         run_cnt_r <= run_cnt_r;
      end
   end

   // Saturating count of active cycles seen while the command is in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_cnt_r <= 4'd0;
      end else if (accept_s) begin
         act_cnt_r <= 4'd0;
      end else if (in_cmd_phase(state_r) && active) begin
         act_cnt_r <= sat_inc4(act_cnt_r);
      end else begin
         act_cnt_r <= act_cnt_r;
      end
   end

   // Result capture when the unit returns to idle; errors leave results alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_y_r <= 8'd0;
         res_s_r <= 3'd0;
         res_b_r <= 1'b0;
      end else if (capture_s) begin
         res_y_r <= y_in;
         res_s_r <= s_in;
         res_b_r <= b_in;
      end else begin
         res_y_r <= res_y_r;
         res_s_r <= res_s_r;
         res_b_r <= res_b_r;
      end
   end

   assign on                 = on_r;
   assign start              = start_r;
   assign x                  = cmd_r.x;
   assign host.cmd_ready     = ready_r;
   assign host.busy          = busy_r;
   assign host.done          = done_r;
   assign host.err           = err_r;
   assign host.res_y         = res_y_r;
   assign host.res_s         = res_s_r;
   assign host.res_b         = res_b_r;
   assign host.active_cycles = act_cnt_r;

endmodule

// File: tb/tb_mode_sequencer.sv
// Scoreboard bench for mode_sequencer: each scenario pushes its expected
// completion record when the command is sent and pops it at done.
module tb_mode_sequencer;
   import mode_seq_pkg::*;

   typedef struct packed {
      logic       err;
      logic [7:0] y;
      logic [2:0] s;
      logic       b;
      logic [3:0] act;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] on;
   logic       start;
   logic [7:0] x;
   logic [1:0] regime;
   logic       active;
   logic [7:0] y_in;
   logic [2:0] s_in;
   logic       b_in;

   exp_t       exp_q[$];
   int         vectors    = 0;
   int         miscompares = 0;
   logic [7:0] m_y = 8'd0;
   logic [2:0] m_s = 3'd0;
   logic       m_b = 1'b0;

   mode_sequencer_if host_if ();

   mode_sequencer #(.TIMEOUT(15)) dut (
      .clk    (clk),
      .rst    (rst),
      .host   (host_if),
      .on     (on),
      .start  (start),
      .x      (x),
      .regime (regime),
      .active (active),
      .y_in   (y_in),
      .s_in   (s_in),
      .b_in   (b_in)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t got_res();
      return {host_if.err, host_if.res_y, host_if.res_s, host_if.res_b, host_if.active_cycles};
   endfunction

   // Unit model: regime shows mode m in cycles [r_on, r_off), active for cycles < a_cnt.
   task automatic drive_unit(input int cyc, input logic [1:0] m, input int r_on, input int r_off, input int a_cnt);
      regime = (cyc >= r_on && cyc < r_off) ? m : MODE_NONE;
      active = (cyc < a_cnt);
      y_in   = 8'hA0 + 8'(cyc);
      s_in   = 3'(cyc);
      b_in   = 1'(cyc);
   endtask

   task automatic send(input logic [1:0] m, input logic [7:0] xv, input logic [3:0] len);
      host_if.cmd_valid = 1'b1;
      host_if.cmd_mode  = m;
      host_if.cmd_x     = xv;
      host_if.cmd_len   = len;
      tick();
      host_if.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      vectors++;
      if ({on, start, x} !== 11'd0) begin
         miscompares++; $display("FAIL reset_unit: got %h want 000", {on, start, x});
      end
      vectors++;
      if ({host_if.busy, host_if.done, host_if.err, host_if.cmd_ready} !== 4'b0001) begin
         miscompares++; $display("FAIL reset_status: got %b want 0001",
            {host_if.busy, host_if.done, host_if.err, host_if.cmd_ready});
      end
      vectors++;
      if (got_res() !== 17'd0) begin
         miscompares++; $display("FAIL reset_results: got %h want 0", got_res());
      end
   endtask

   task automatic test_mode0();
      exp_t e, g;
      int   done_cyc = -1;
      e = '{1'b0, m_y, m_s, m_b, 4'd0};
      exp_q.push_back(e);
      send(MODE_NONE, 8'h33, 4'd5);
      for (int c = 0; c < 4; c++) begin
         drive_unit(c, MODE_NONE, 0, 0, 0);
         vectors++;
         if ({on, start} !== 3'd0) begin
            miscompares++; $display("FAIL mode0_onstart cyc %0d: got %b want 000", c, {on, start});
         end
         if (host_if.done === 1'b1 && done_cyc < 0) begin
            done_cyc = c;
            g = exp_q.pop_front();
            vectors++;
            if (got_res() !== g) begin
               miscompares++; $display("FAIL mode0_result: got %h want %h", got_res(), g);
            end
         end
         tick();
      end
      vectors++;
      if (done_cyc != 0) begin
         miscompares++; $display("FAIL mode0_latency: got %0d want 0", done_cyc);
      end
   endtask

   task automatic test_upd_len0();
      exp_t e, g;
      int   done_cyc = -1;
      e = '{1'b0, 8'hA3, 3'd3, 1'b1, 4'd0};
      exp_q.push_back(e);
      send(MODE_UPD, 8'h3C, 4'd0);
      for (int c = 0; c < 20 && done_cyc < 0; c++) begin
         drive_unit(c, MODE_UPD, 0, 3, 0);
         vectors++;
         if (start !== 1'b0) begin
            miscompares++; $display("FAIL upd_start cyc %0d: got %b want 0", c, start);
         end
         if (host_if.done === 1'b1) begin
            done_cyc = c;
            g = exp_q.pop_front();
            vectors++;
            if (got_res() !== g) begin
               miscompares++; $display("FAIL upd_result: got %h want %h", got_res(), g);
            end
         end
         tick();
      end
      vectors++;
      if (done_cyc != 4) begin
         miscompares++; $display("FAIL upd_latency: got %0d want 4", done_cyc);
      end
      m_y = 8'hA3; m_s = 3'd3; m_b = 1'b1;
   endtask

   task automatic test_count_run();
      exp_t e, g;
      int   done_cyc = -1;
      int   start_cnt = 0;
      e = '{1'b0, 8'hA7, 3'd7, 1'b1, 4'd0};
      exp_q.push_back(e);
      send(MODE_COUNT, 8'd5, 4'd4);
      for (int c = 0; c < 30 && done_cyc < 0; c++) begin
         drive_unit(c, MODE_COUNT, 0, 7, 0);
         if (start === 1'b1) start_cnt++;
         vectors++;
         if (x !== 8'd5) begin
            miscompares++; $display("FAIL count_x cyc %0d: got %h want 05", c, x);
         end
         if (host_if.done === 1'b1) begin
            done_cyc = c;
            g = exp_q.pop_front();
            vectors++;
            if (got_res() !== g) begin
               miscompares++; $display("FAIL count_result: got %h want %h", got_res(), g);
            end
         end
         tick();
      end
      vectors++;
      if (start_cnt != 5) begin
         miscompares++; $display("FAIL count_start_cycles: got %0d want 5", start_cnt);
      end
      vectors++;
      if (done_cyc != 8) begin
         miscompares++; $display("FAIL count_latency: got %0d want 8", done_cyc);
      end
      vectors++;
      if ({x, host_if.cmd_ready} !== {8'd5, 1'b1}) begin
         miscompares++; $display("FAIL count_idle_x: got %h want 0b", {x, host_if.cmd_ready});
      end
      m_y = 8'hA7; m_s = 3'd7; m_b = 1'b1;
   endtask

   task automatic test_active_count();
      exp_t e, g;
      int   done_cyc = -1;
      e = '{1'b0, 8'hA5, 3'd5, 1'b1, 4'd6};
      exp_q.push_back(e);
      send(MODE_ENUM, 8'h11, 4'd2);
      for (int c = 0; c < 30 && done_cyc < 0; c++) begin
         drive_unit(c, MODE_ENUM, 0, 5, 6);
         if (host_if.done === 1'b1) begin
            done_cyc = c;
            g = exp_q.pop_front();
            vectors++;
            if (got_res() !== g) begin
               miscompares++; $display("FAIL active_result: got %h want %h", got_res(), g);
            end
         end
         tick();
      end
      active = 1'b0;
      vectors++;
      if (done_cyc != 6) begin
         miscompares++; $display("FAIL active_latency: got %0d want 6", done_cyc);
      end
      m_y = 8'hA5; m_s = 3'd5; m_b = 1'b1;
   endtask

   task automatic test_timeout();
      exp_t e, g;
      int   done_cyc = -1;
      int   arm_cnt = 0;
      e = '{1'b1, m_y, m_s, m_b, 4'd0};
      exp_q.push_back(e);
      send(MODE_COUNT, 8'h42, 4'd3);
      for (int c = 0; c < 40 && done_cyc < 0; c++) begin
         drive_unit(c, MODE_COUNT, 0, 0, 0);
         if (host_if.done === 1'b1) begin
            done_cyc = c;
            g = exp_q.pop_front();
            vectors++;
            if (got_res() !== g) begin
               miscompares++; $display("FAIL timeout_result: got %h want %h", got_res(), g);
            end
            vectors++;
            if ({on, start} !== 3'd0) begin
               miscompares++; $display("FAIL timeout_onstart: got %b want 000", {on, start});
            end
         end else if (host_if.busy === 1'b1) begin
            arm_cnt++;
            vectors++;
            if (on !== MODE_COUNT) begin
               miscompares++; $display("FAIL timeout_on cyc %0d: got %0d want 2", c, on);
            end
         end
         tick();
      end
      vectors++;
      if (arm_cnt != 15 || done_cyc != 15) begin
         miscompares++; $display("FAIL timeout_arm_cycles: got %0d/%0d want 15/15", arm_cnt, done_cyc);
      end
   endtask

   task automatic test_late_match();
      exp_t e, g;
      int   done_cyc = -1;
      e = '{1'b0, 8'hAF, 3'd7, 1'b1, 4'd0};
      exp_q.push_back(e);
      send(MODE_ENUM, 8'h5A, 4'd0);
      for (int c = 0; c < 40 && done_cyc < 0; c++) begin
         drive_unit(c, MODE_ENUM, 14, 15, 0);
         if (host_if.done === 1'b1) begin
            done_cyc = c;
            g = exp_q.pop_front();
            vectors++;
            if (got_res() !== g) begin
               miscompares++; $display("FAIL late_match_result: got %h want %h", got_res(), g);
            end
         end
         tick();
      end
      vectors++;
      if (done_cyc != 16) begin
         miscompares++; $display("FAIL late_match_latency: got %0d want 16", done_cyc);
      end
      m_y = 8'hAF; m_s = 3'd7; m_b = 1'b1;
   endtask

   task automatic test_reset_mid_run();
      exp_t e, g;
      int   done_cyc = -1;
      int   stray = 0;
      send(MODE_COUNT, 8'h77, 4'd8);
      for (int c = 0; c < 3; c++) begin
         drive_unit(c, MODE_COUNT, 0, 20, 0);
         tick();
      end
      drive_unit(3, MODE_COUNT, 0, 20, 0);
      vectors++;
      if ({on, start} !== {MODE_COUNT, 1'b1}) begin
         miscompares++; $display("FAIL midrun_pre: got %b want 101", {on, start});
      end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if ({on, start, host_if.busy, host_if.done, host_if.cmd_ready} !== 6'b000001) begin
         miscompares++; $display("FAIL midrun_reset: got %b want 000001",
            {on, start, host_if.busy, host_if.done, host_if.cmd_ready});
      end
      rst = 1'b0;
      regime = MODE_NONE;
      m_y = 8'd0; m_s = 3'd0; m_b = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (host_if.done === 1'b1) stray++;
      end
      vectors++;
      if (stray != 0) begin
         miscompares++; $display("FAIL midrun_stray_done: got %0d want 0", stray);
      end
      e = '{1'b0, 8'hA3, 3'd3, 1'b1, 4'd0};
      exp_q.push_back(e);
      send(MODE_UPD, 8'h21, 4'd1);
      for (int c = 0; c < 30 && done_cyc < 0; c++) begin
         drive_unit(c, MODE_UPD, 0, 3, 0);
         if (host_if.done === 1'b1) begin
            done_cyc = c;
            g = exp_q.pop_front();
            vectors++;
            if (got_res() !== g) begin
               miscompares++; $display("FAIL midrun_after_result: got %h want %h", got_res(), g);
            end
         end
         tick();
      end
      vectors++;
      if (done_cyc != 4) begin
         miscompares++; $display("FAIL midrun_after_latency: got %0d want 4", done_cyc);
      end
      m_y = 8'hA3; m_s = 3'd3; m_b = 1'b1;
   endtask

   task automatic test_back_to_back();
      exp_t e, g;
      int   dones = 0;
      e = '{1'b0, m_y, m_s, m_b, 4'd0};
      exp_q.push_back(e);
      exp_q.push_back(e);
      host_if.cmd_valid = 1'b1;
      host_if.cmd_mode  = MODE_NONE;
      host_if.cmd_x     = 8'h99;
      host_if.cmd_len   = 4'd0;
      tick();
      for (int c = 0; c < 6; c++) begin
         if (c == 2) host_if.cmd_valid = 1'b0;
         vectors++;
         if ({host_if.done, host_if.cmd_ready} !== {(c == 0 || c == 2), !(c == 0 || c == 2)}) begin
            miscompares++; $display("FAIL b2b_done_ready cyc %0d: got %b want %b", c,
               {host_if.done, host_if.cmd_ready}, {(c == 0 || c == 2), !(c == 0 || c == 2)});
         end
         if (host_if.done === 1'b1) begin
            dones++;
            g = exp_q.pop_front();
            vectors++;
            if (got_res() !== g) begin
               miscompares++; $display("FAIL b2b_result: got %h want %h", got_res(), g);
            end
         end
         tick();
      end
      vectors++;
      if (dones != 2 || exp_q.size() != 0) begin
         miscompares++; $display("FAIL b2b_count: got %0d dones, %0d left want 2, 0", dones, exp_q.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      host_if.cmd_valid = 1'b0;
      host_if.cmd_mode  = MODE_NONE;
      host_if.cmd_x     = 8'd0;
      host_if.cmd_len   = 4'd0;
      regime = MODE_NONE;
      active = 1'b0;
      y_in   = 8'd0;
      s_in   = 3'd0;
      b_in   = 1'b0;
      tick();
      tick();
      test_reset();
      rst = 1'b0;
      tick();
      test_mode0();
      test_upd_len0();
      test_count_run();
      test_active_count();
      test_timeout();
      test_late_match();
      test_reset_mid_run();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
